// File: rtl/micro_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// A small IDLE/RUN/DONE controller sequences a shift/subtract datapath.
module micro_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;

  logic [VW:0]   t;
  logic          t_ge;
  logic [VW-1:0] r_step;
  logic [DW-1:0] q_step;
  logic          last_step;

  // R < D after every step, so the stored partial remainder needs only VW bits;
  // the trial value and compare still carry the extra shifted-in bit.
  assign t         = {r_q, q_q[DW-1]};
  assign t_ge      = (t >= {1'b0, d_q});
  assign r_step    = t_ge ? VW'(t - {1'b0, d_q}) : t[VW-1:0];
  assign q_step    = {q_q[DW-2:0], t_ge};
  assign last_step = (cnt_q == CW'(DW - 1));

  // Controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div0_d = div0_q;
    case (state_q)
      IDLE: begin
        if (start && divisor != '0) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
        end else if (start) begin
          quo_d  = '1;
          rem_d  = '0;
          div0_d = 1'b1;
        end
      end
      RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          quo_d  = q_step;
          rem_d  = r_step;
          div0_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_micro_divider.sv
// Bench for micro_divider: directed scenarios plus a shuffled sweep of every
// nonzero-divisor pair, checked against plain integer division.
module tb_micro_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  micro_divider #(.DW(DW), .VW(VW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Issues one division from IDLE and returns in the done cycle (or on timeout).
  // With hold set, start stays high with 100/3 applied for the whole run.
  task automatic div_and_check(input int a, input int b, input bit hold, input string name);
    int lat;
    int nbusy;
    int exp_q, exp_r, exp_d0;
    if (b == 0) begin
      exp_q  = (1 << DW) - 1;
      exp_r  = 0;
      exp_d0 = 1;
    end else begin
      exp_q  = a / b;
      exp_r  = a % b;
      exp_d0 = 0;
    end
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    step(1);
    if (hold) begin
      dividend = DW'(100);
      divisor  = VW'(3);
    end else begin
      start = 1'b0;
    end
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      step(1);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(DW + 1));
    check({name, "_busy_cycles"}, 32'(nbusy), (b == 0) ? 32'd0 : 32'(DW));
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
    check({name, "_quotient"}, 32'(quotient), 32'(exp_q));
    check({name, "_remainder"}, 32'(remainder), 32'(exp_r));
    check({name, "_div0"}, 32'(div0), 32'(exp_d0));
    $display("%s: %0d/%0d -> q=%0d r=%0d div0=%0d latency=%0d busy=%0d",
             name, a, b, quotient, remainder, div0, lat, nbusy);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_quotient"}, 32'(quotient), 32'd0);
    check({name, "_remainder"}, 32'(remainder), 32'd0);
    check({name, "_div0"}, 32'(div0), 32'd0);
  endtask

  int idx [256*15];

  initial begin
    int c1;
    int ndone;
    int nbusy;
    int tmp, j, a, b;

    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_zero_outputs("reset_async");
    step(2);
    sys_rst = 1'b0;
    step(1);
    check_zero_outputs("reset_release");

    // Basic division
    div_and_check(200, 7, 1'b0, "basic");
    step(1);
    check("hold_quotient", 32'(quotient), 32'd28);
    check("hold_remainder", 32'(remainder), 32'd4);

    // Back-to-back, second start in the first IDLE cycle
    div_and_check(255, 15, 1'b0, "b2b_first");
    c1 = cyc;
    step(1);
    div_and_check(5, 9, 1'b0, "b2b_second");
    check("b2b_done_gap", 32'(cyc - c1), 32'(DW + 2));
    step(1);

    // Divide by zero, then a normal follow-up
    div_and_check(13, 0, 1'b0, "div0");
    step(1);
    div_and_check(13, 1, 1'b0, "after_div0");
    step(1);

    // start held through RUN and DONE is ignored; one accept in first IDLE
    div_and_check(200, 7, 1'b1, "ignore_start");
    step(1);
    check("ignore_idle_busy", 32'(busy), 32'd0);
    check("ignore_idle_done", 32'(done), 32'd0);
    div_and_check(100, 3, 1'b0, "requeue");
    step(1);
    nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy || done) nbusy++;
      step(1);
    end
    check("no_extra_accept", 32'(nbusy), 32'd0);

    // Reset pulse after the 4th RUN edge
    start    = 1'b1;
    dividend = DW'(200);
    divisor  = VW'(7);
    step(1);
    start = 1'b0;
    step(4);
    check("midrun_busy", 32'(busy), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    check_zero_outputs("midrun_reset");
    step(1);
    sys_rst = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      step(1);
    end
    check("midrun_no_done", 32'(ndone), 32'd0);
    check("midrun_no_busy", 32'(nbusy), 32'd0);
    $display("midrun_reset: outputs cleared, no done");
    div_and_check(0, 5, 1'b0, "after_reset");
    step(1);

    // Shuffled sweep of all nonzero-divisor pairs
    for (int i = 0; i < 256*15; i++) idx[i] = i;
    for (int i = 256*15 - 1; i > 0; i--) begin
      j      = int'($urandom_range(i, 0));
      tmp    = idx[i];
      idx[i] = idx[j];
      idx[j] = tmp;
    end
    for (int i = 0; i < 256*15; i++) begin
      a = idx[i] / 15;
      b = (idx[i] % 15) + 1;
      div_and_check(a, b, 1'b0, "sweep");
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
